// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

  localparam int max_data_width = 9;

  typedef enum logic [1:0] {
    parity_none = 2'd0,
    parity_even = 2'd1,
    parity_odd  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    idle   = 3'd0,
    start  = 3'd1,
    data   = 3'd2,
    parity = 3'd3,
    stop   = 3'd4
  } tx_state_t;

  // The reserved encoding 3 behaves as "no parity".
  function automatic parity_t decode_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return parity_even;
      2'd2:    return parity_odd;
      default: return parity_none;
    endcase
  endfunction

  // Callers zero-extend the word, so unused upper bits do not disturb the XOR.
  function automatic logic parity_bit(input logic [max_data_width-1:0] word,
                                      input parity_t mode);
    return (mode == parity_odd) ? ~(^word) : ^word;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with valid/ready on both sides and an occupancy count.
module uart_sync_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [width-1:0]         wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [width-1:0]         rd_data,
  output logic [$clog2(depth):0]   count
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = ptr_w + 1;

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign wr_ready = (count != cnt_w'(depth));
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an AXI-stream FIFO; frame format chosen per word at pop time.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int data_width    = 8,
  parameter int divisor_width = 16,
  parameter int fifo_depth    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     tx,
  output logic                     tready,
  input  logic                     tvalid,
  input  logic [data_width-1:0]    tdata,
  input  logic [divisor_width-1:0] cycles_per_bit,
  input  logic [1:0]               parity_mode,
  input  logic                     two_stop,
  output logic                     busy
);

  localparam int idx_w = $clog2(data_width + 1);
  localparam int cnt_w = $clog2(fifo_depth) + 1;
  localparam logic [idx_w-1:0] last_data_idx = idx_w'(data_width - 1);

  logic                     alive;
  logic                     fifo_wr_ready;
  logic                     fifo_rd_valid;
  logic [data_width-1:0]    head;
  logic [cnt_w-1:0]         fifo_count;
  logic                     pop;

  tx_state_t                state;
  logic [divisor_width-1:0] bit_cnt;
  logic [divisor_width-1:0] period_q;
  logic [idx_w-1:0]         bit_idx;
  logic [data_width-1:0]    shift_q;
  logic                     parity_en_q;
  logic                     parity_q;
  logic                     two_stop_q;

  parity_t                  mode_in;
  logic                     bit_done;
  logic                     last_stop;
  logic                     tx_next;

  // tready is held low until the first edge after reset release.
  assign tready = fifo_wr_ready && alive;

  uart_sync_fifo #(
    .width (data_width),
    .depth (fifo_depth)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (tvalid && alive),
    .wr_ready (fifo_wr_ready),
    .wr_data  (tdata),
    .rd_valid (fifo_rd_valid),
    .rd_ready (pop),
    .rd_data  (head),
    .count    (fifo_count)
  );

  assign mode_in   = decode_parity(parity_mode);
  assign bit_done  = (bit_cnt == period_q - divisor_width'(1));
  assign last_stop = (bit_idx == idx_w'(two_stop_q));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pop = 1'b0;
    if (fifo_rd_valid) begin
      if (state == idle)                                pop = 1'b1;
      else if (state == stop && bit_done && last_stop)  pop = 1'b1;
    end
  end

  always_comb begin
    tx_next = 1'b1;
    case (state)
      start:   tx_next = 1'b0;
      data:    tx_next = shift_q[0];
      parity:  tx_next = parity_q;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive       <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      state       <= idle;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      period_q    <= divisor_width'(1);
      shift_q     <= '0;
      parity_en_q <= 1'b0;
      parity_q    <= 1'b0;
      two_stop_q  <= 1'b0;
    end else begin
      alive <= 1'b1;
      tx    <= tx_next;
      busy  <= (fifo_count != '0) || (state != idle);

      if (pop) begin
        // Frame configuration is frozen here for the whole frame.
        state       <= start;
        bit_cnt     <= '0;
        bit_idx     <= '0;
        shift_q     <= head;
        period_q    <= (cycles_per_bit == '0) ? divisor_width'(1) : cycles_per_bit;
        parity_en_q <= (mode_in != parity_none);
        parity_q    <= parity_bit(max_data_width'(head), mode_in);
        two_stop_q  <= two_stop;
      end else begin
        case (state)
          start: begin
            if (bit_done) begin
              state   <= data;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          data: begin
            if (bit_done) begin
              bit_cnt <= '0;
              shift_q <= shift_q >> 1;
              if (bit_idx == last_data_idx) begin
                bit_idx <= '0;
                state   <= parity_en_q ? parity : stop;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          parity: begin
            if (bit_done) begin
              bit_cnt <= '0;
              state   <= stop;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          stop: begin
            if (bit_done) begin
              bit_cnt <= '0;
              if (last_stop) state   <= idle;
              else           bit_idx <= bit_idx + 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: state <= idle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8-bit instance and a 7-bit instance share clock and reset.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tdata;
  logic [15:0] cpb;
  logic [1:0]  pmode;
  logic        two_stop;

  logic tx8, tready8, busy8, tvalid8;
  logic tx7, tready7, busy7, tvalid7;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.data_width(8), .divisor_width(16), .fifo_depth(4)) u_dut8 (
    .clk            (clk),
    .rst            (rst),
    .tx             (tx8),
    .tready         (tready8),
    .tvalid         (tvalid8),
    .tdata          (tdata),
    .cycles_per_bit (cpb),
    .parity_mode    (pmode),
    .two_stop       (two_stop),
    .busy           (busy8)
  );

  uart_tx_fifo #(.data_width(7), .divisor_width(16), .fifo_depth(4)) u_dut7 (
    .clk            (clk),
    .rst            (rst),
    .tx             (tx7),
    .tready         (tready7),
    .tvalid         (tvalid7),
    .tdata          (tdata[6:0]),
    .cycles_per_bit (cpb),
    .parity_mode    (pmode),
    .two_stop       (two_stop),
    .busy           (busy7)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start, data LSB first, optional parity, one or two stops; bit 0 goes out first.
  function automatic void make_frame(input logic [8:0] word, input int dw, input int pm,
                                     input bit ts, output logic [15:0] bits, output int n);
    logic p;
    bits = '0;
    p    = 1'b0;
    n    = 1;
    for (int i = 0; i < dw; i++) begin
      bits[n] = word[i];
      p       = p ^ word[i];
      n++;
    end
    if (pm == 1) begin bits[n] = p;  n++; end
    if (pm == 2) begin bits[n] = ~p; n++; end
    bits[n] = 1'b1; n++;
    if (ts) begin bits[n] = 1'b1; n++; end
  endfunction

  // Called at the negedge where bit 0 should be on the line; returns at the negedge after the last bit.
  task automatic run_bits(input string tag, input bit which, input logic [127:0] bits,
                          input int nbits, input int period);
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < period; c++) begin
        check(tag, which ? tx7 : tx8, bits[k]);
        check({tag, "_busy"}, which ? busy7 : busy8, 1'b1);
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_tx_low(input bit which, input int max_cycles, input string tag);
    int i = 0;
    while ((which ? tx7 : tx8) !== 1'b0 && i < max_cycles) begin
      @(negedge clk);
      i++;
    end
    check(tag, (which ? tx7 : tx8) === 1'b0, 1'b1);
  endtask

  // Called at a negedge; the handshake happens at the next posedge; returns at the following negedge.
  task automatic push8(input logic [7:0] w);
    tdata   = w;
    tvalid8 = 1'b1;
    check("push_tready", tready8, 1'b1);
    @(negedge clk);
    tvalid8 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [127:0] exp_burst;
  logic [15:0]  fr1, fr2;
  int           n1, n2, pos, acc, guard, lows, busy_hi;
  logic         rdy;

  initial begin
    rst      = 1'b1;
    tvalid8  = 1'b0;
    tvalid7  = 1'b0;
    tdata    = '0;
    cpb      = 16'd4;
    pmode    = 2'd0;
    two_stop = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx8", tx8, 1'b1);
    check("rst_tready8", tready8, 1'b0);
    check("rst_busy8", busy8, 1'b0);
    check("rst_tx7", tx7, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("rel_tready8", tready8, 1'b1);
    check("rel_tready7", tready7, 1'b1);
    check("rel_tx8", tx8, 1'b1);
    check("rel_busy8", busy8, 1'b0);
    repeat (3) @(negedge clk);

    // 0xA5, period 4, even parity, one stop; tx low exactly two edges after the handshake
    cpb = 16'd4; pmode = 2'd1; two_stop = 1'b0;
    push8(8'hA5);
    check("a5_lat_n", tx8, 1'b1);
    @(negedge clk);
    check("a5_lat_n1", tx8, 1'b1);
    check("a5_busy_n1", busy8, 1'b1);
    @(negedge clk);
    run_bits("a5", 1'b0, 128'(11'b10101001010), 11, 4);
    check("a5_busy_end", busy8, 1'b0);
    check("a5_tx_idle", tx8, 1'b1);
    repeat (2) @(negedge clk);

    // 7-bit instance: 0x07, period 3, odd parity, two stops (33 clocks)
    cpb = 16'd3; pmode = 2'd2; two_stop = 1'b1;
    tdata = 8'h07; tvalid7 = 1'b1;
    @(negedge clk);
    tvalid7 = 1'b0;
    check("w7_lat_n", tx7, 1'b1);
    @(negedge clk);
    check("w7_lat_n1", tx7, 1'b1);
    @(negedge clk);
    run_bits("w7", 1'b1, 128'(11'b11000001110), 11, 3);
    check("w7_busy_end", busy7, 1'b0);
    repeat (2) @(negedge clk);

    // Burst of six words through a four-deep FIFO, frames back-to-back
    cpb = 16'd2; pmode = 2'd0; two_stop = 1'b0;
    exp_burst = '0;
    pos = 0;
    for (int w = 1; w <= 6; w++) begin
      make_frame(9'(w), 8, 0, 1'b0, fr1, n1);
      exp_burst = exp_burst | (128'(fr1) << pos);
      pos += n1;
    end
    fork
      begin
        acc = 0; guard = 0;
        tdata = 8'h01; tvalid8 = 1'b1;
        while (acc < 6 && guard < 400) begin
          rdy = tready8;
          @(negedge clk);
          guard++;
          if (rdy) begin
            acc++;
            if (acc == 5) check("burst_full_tready", tready8, 1'b0);
            tdata = 8'(acc + 1);
          end
        end
        tvalid8 = 1'b0;
        check("burst_accepted", acc, 6);
      end
      begin
        wait_tx_low(1'b0, 10, "burst_start");
        run_bits("burst", 1'b0, exp_burst, pos, 2);
      end
    join
    check("burst_busy_end", busy8, 1'b0);
    check("burst_tx_idle", tx8, 1'b1);
    repeat (2) @(negedge clk);

    // Config change mid-frame applies only to the next frame
    cpb = 16'd4; pmode = 2'd0; two_stop = 1'b0;
    make_frame(9'h05A, 8, 0, 1'b0, fr1, n1);
    make_frame(9'h0C3, 8, 2, 1'b0, fr2, n2);
    fork
      begin
        push8(8'h5A);
        push8(8'hC3);
        repeat (12) @(negedge clk);
        cpb = 16'd8; pmode = 2'd2;
      end
      begin
        wait_tx_low(1'b0, 10, "chg_start");
        run_bits("chg_f1", 1'b0, 128'(fr1), n1, 4);
        run_bits("chg_f2", 1'b0, 128'(fr2), n2, 8);
      end
    join
    check("chg_busy_end", busy8, 1'b0);
    repeat (2) @(negedge clk);

    // Reset during data bits of 0x3C with two words queued
    cpb = 16'd4; pmode = 2'd0; two_stop = 1'b0;
    push8(8'h3C);
    push8(8'h11);
    push8(8'h22);
    repeat (5) @(negedge clk);
    check("rstmid_pre_tx", tx8, 1'b0);
    check("rstmid_pre_busy", busy8, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_tx", tx8, 1'b1);
    check("rstmid_busy", busy8, 1'b0);
    check("rstmid_tready", tready8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    lows = 0; busy_hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx8 !== 1'b1) lows++;
      if (busy8 !== 1'b0) busy_hi++;
    end
    check("rstmid_no_tx", lows, 0);
    check("rstmid_no_busy", busy_hi, 0);
    check("rstmid_tready_after", tready8, 1'b1);

    // Period 0 behaves as one clock per bit
    cpb = 16'd0; pmode = 2'd0; two_stop = 1'b0;
    make_frame(9'h096, 8, 0, 1'b0, fr1, n1);
    push8(8'h96);
    @(negedge clk);
    check("div0_lat_n1", tx8, 1'b1);
    @(negedge clk);
    run_bits("div0", 1'b0, 128'(fr1), n1, 1);
    check("div0_busy_end", busy8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Accepts words on an AXI-stream slave into an internal FIFO and serialises them LSB-first on one line. Frame format is selected at run time: data width fixed by parameter, runtime bit period, parity none/even/odd, one or two stop bits. Sits between a byte/word producer (e.g. a bus bridge) and the tx pin.

Parameters:
data_width, 8, data bits per frame; legal range 5..9.
divisor_width, 16, width of the runtime cycles_per_bit input.
fifo_depth, 4, FIFO entries; power of two, at least 2.

Ports:
clk  input  1  clock.
rst  input  1  asynchronous reset, active-high.
tx  output  1  serial output; idles high.
tready  output  1  AXI-stream ready; high when FIFO not full.
tvalid  input  1  AXI-stream valid.
tdata  input  data_width  word to send.
cycles_per_bit  input  divisor_width  clocks per bit; value 0 treated as 1.
parity_mode  input  2  0 none, 1 even, 2 odd, 3 reserved (treated as none).
two_stop  input  1  1 = two stop bits, 0 = one.
busy  output  1  high while FIFO non-empty or a frame is on the line.

Behaviour:
- Reset (async assert): tx=1, tready=0 while rst high, busy=0, FIFO emptied, FSM idle, counters 0. First clock after release: tready=1.
- Reset mid-frame: tx returns to 1 immediately, partial frame abandoned, queued words discarded.
- Push: tvalid && tready at a rising edge writes tdata. tready = (count != fifo_depth), registered/derived from count only, never from tvalid.
- Simultaneous push and pop: count unchanged; allowed when full because tready is already low, so no push occurs that cycle.
- FSM states: idle, start, data, parity, stop.
  - idle: if FIFO non-empty, pop head; latch word, cycles_per_bit, parity_mode, two_stop into frame registers; go to start.
  - Config inputs are sampled only at pop; changes mid-frame have no effect on the current frame.
- Per-state line value: start drives 0; data drives word bits LSB-first; parity drives XOR of data (even) or its inverse (odd); stop drives 1.
- Bit counter runs 0..period-1. Each bit lasts exactly period clocks.
- data state: advances after data_width bits. Goes to parity if mode is even/odd, else to stop.
- stop state: lasts 1 or 2 bit periods. At its end, pops the next word if the FIFO is non-empty and goes straight to start (no idle gap between frames); otherwise goes to idle.
- Latency: with FIFO empty and FSM idle, a word accepted at edge N makes tx low at edge N+2.
- Frame length: (1 + data_width + parity_bits + stop_bits) × period clocks.
- busy: registered. Falls the cycle after the last stop bit completes with the FIFO empty.
- Counter widths: bit-period counter is divisor_width; bit index is $clog2(data_width+1). No wrap is possible within a legal frame.

Decomposition:
- Package uart_pkg holds:
  - parity_t enum: parity_none, parity_even, parity_odd.
  - tx_state_t enum: idle, start, data, parity, stop.
  - parity helper function.
- Sub-module uart_sync_fifo: single-clock FIFO, parameters width and depth, ports clk, rst, wr_valid/wr_ready/wr_data, rd_valid/rd_ready/rd_data, count.
- The transmitter FSM lives in uart_tx_fifo itself.

Test Plan:
- Reset release, no stimulus -> tx=1, busy=0, tready=1 from the first cycle after rst falls.
- data_width=8, period=4, even parity, one stop, send 0xA5 -> tx low at N+2. Bit sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each held 4 clocks. busy drops after 44 cycles of frame.
- data_width=7, period=3, odd parity, two stop, send 0x07 -> bits 0,1,1,1,0,0,0,0,0(parity),1,1. Frame is 33 clocks.
- Burst of 6 words 0x01..0x06 with tvalid held, depth 4, period=2, none/one-stop -> tready low while 4 entries are queued. All 6 frames sent in order, back-to-back, stop bit immediately followed by start bit.
- Change period 4->8 and parity none->odd mid-frame -> current frame unaffected; next frame uses 8 and odd.
- Assert rst in the middle of the data bits of 0x3C with 2 words queued -> tx=1 asynchronously. Nothing is transmitted after release.
- period=0 -> each bit lasts 1 clock.
